// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Defines the loader FSM state encoding, the frame start byte and the word size.
package loader_pkg;

  localparam logic [7:0] LD_HEADER     = 8'hA5;
  localparam int         LD_WORD_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } ld_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream receive handshake plus program-memory write port of the loader.
// The loader uses the slave side; the byte source and the memory use the master side.
interface program_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               pm_we;
  logic [ADDR_W-1:0]  pm_addr;
  logic [INSTR_W-1:0] pm_wdata;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, pm_we, pm_addr, pm_wdata
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, pm_we, pm_addr, pm_wdata
  );

endinterface

// File: rtl/program_loader.sv
// Assembles 16-bit instruction words from a framed byte stream into program memory
// and holds the core until a frame with a good checksum has been written.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] HEADER  = LD_HEADER,
  parameter int         ADDR_W  = 8,
  parameter int         INSTR_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  program_loader_if.slave  bus,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  ld_state_t          state_q, state_d;
  logic [7:0]         hi_q, hi_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic               rx_ready_q;
  logic               pm_we_q, pm_we_d;
  logic [ADDR_W-1:0]  pm_addr_q, pm_addr_d;
  logic [INSTR_W-1:0] pm_wdata_q, pm_wdata_d;
  logic               hold_q, hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept;

  assign accept = bus.rx_valid && rx_ready_q;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;
    done_d     = done_q;
    err_d      = err_q;

    if (accept) begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (bus.rx_data == HEADER) begin
            state_d = LEN;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        LEN: begin
          // A length byte of zero encodes a full 256-word image.
          cnt_d   = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
          addr_d  = '0;
          csum_d  = 8'd0;
          state_d = HI;
        end
        HI: begin
          hi_d    = bus.rx_data;
          csum_d  = csum_q + bus.rx_data;
          state_d = LO;
        end
        LO: begin
          csum_d     = csum_q + bus.rx_data;
          pm_we_d    = 1'b1;
          pm_addr_d  = addr_q;
          pm_wdata_d = {hi_q, bus.rx_data};
          addr_d     = addr_q + ADDR_W'(1);
          cnt_d      = cnt_q - 9'd1;
          state_d    = (cnt_q == 9'd1) ? CSUM : HI;
        end
        CSUM: begin
          if (bus.rx_data == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == LEN) || (state_d == HI) || (state_d == LO) || (state_d == CSUM);
    hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      hi_q       <= 8'd0;
      addr_q     <= '0;
      cnt_q      <= 9'd0;
      csum_q     <= 8'd0;
      rx_ready_q <= 1'b1;
      pm_we_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      rx_ready_q <= 1'b1;
      pm_we_q    <= pm_we_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.pm_we    = pm_we_q;
  assign bus.pm_addr  = pm_addr_q;
  assign bus.pm_wdata = pm_wdata_q;
  assign core_hold    = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a frame-level reference model.
// The model derives expected writes and final status straight from the frame contents.
module tb_program_loader;

  logic clk = 1'b0;
  logic clr;
  logic coreHold, busy, done, err;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0]  pay [0:511];
  logic [7:0]  obsAddr [$];
  logic [15:0] obsData [$];

  program_loader_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  program_loader #(.HEADER(8'hA5), .ADDR_W(8), .INSTR_W(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus.slave),
    .core_hold (coreHold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Every write strobe seen by memory is captured mid-cycle for later comparison.
  always @(negedge clk) begin
    if (bus.pm_we === 1'b1) begin
      obsAddr.push_back(bus.pm_addr);
      obsData.push_back(bus.pm_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offers one byte after an idle gap; time is always left at posedge + 1.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic sendBody(input int words, input bit corrupt, input int maxGap, output bit good);
    logic [7:0] sum;
    logic [7:0] lenByte;
    sum = 8'd0;
    for (int i = 0; i < 2 * words; i++) sum = sum + pay[i];
    lenByte = (words == 256) ? 8'd0 : 8'(words);
    good = !corrupt;
    applyStimulus(lenByte, $urandom_range(0, maxGap));
    for (int i = 0; i < 2 * words; i++) applyStimulus(pay[i], $urandom_range(0, maxGap));
    applyStimulus(corrupt ? sum + 8'd1 : sum, $urandom_range(0, maxGap));
  endtask

  task automatic checkFrame(input int words, input bit good, input string tag);
    int n;
    checkOutput({tag, ".done"}, 32'(done), 32'(good));
    checkOutput({tag, ".err"}, 32'(err), 32'(!good));
    checkOutput({tag, ".hold"}, 32'(coreHold), 32'(!good));
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, ".wrCount"}, 32'(obsAddr.size()), 32'(words));
    n = (obsAddr.size() < words) ? obsAddr.size() : words;
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, ".wrAddr"}, 32'(obsAddr[i]), 32'(i % 256));
      checkOutput({tag, ".wrData"}, 32'(obsData[i]), {16'd0, pay[2*i], pay[2*i+1]});
    end
  endtask

  task automatic runFrame(input int words, input bit corrupt, input int maxGap, input int garbage, input string tag);
    logic [7:0] g;
    bit good;
    obsAddr.delete();
    obsData.delete();
    for (int i = 0; i < garbage; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      applyStimulus(g, $urandom_range(0, maxGap));
    end
    if (garbage > 0) checkOutput({tag, ".garbageBusy"}, 32'(busy), 32'd0);
    applyStimulus(8'hA5, $urandom_range(0, maxGap));
    sendBody(words, corrupt, maxGap, good);
    checkFrame(words, good, tag);
  endtask

  task automatic loadTwoWord();
    pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'hAB; pay[3] = 8'hCD;
  endtask

  initial begin
    bit good;
    int words;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ready", 32'(bus.rx_ready), 32'd1);
    checkOutput("rst.we", 32'(bus.pm_we), 32'd0);
    checkOutput("rst.addr", 32'(bus.pm_addr), 32'd0);
    checkOutput("rst.wdata", 32'(bus.pm_wdata), 32'd0);
    checkOutput("rst.hold", 32'(coreHold), 32'd1);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.err", 32'(err), 32'd0);
    clr = 1'b0;

    $display("[TB] good 2-word frame");
    loadTwoWord();
    runFrame(2, 1'b0, 0, 0, "good2");

    $display("[TB] bad checksum");
    runFrame(2, 1'b1, 0, 0, "bad2");

    $display("[TB] garbage then good frame");
    obsAddr.delete();
    obsData.delete();
    applyStimulus(8'h00, 0);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h5A, 0);
    checkOutput("garbage.busy", 32'(busy), 32'd0);
    checkOutput("garbage.err", 32'(err), 32'd1);
    applyStimulus(8'hA5, 0);
    sendBody(2, 1'b0, 0, good);
    checkFrame(2, good, "garbage");

    $display("[TB] re-arm after good frame");
    obsAddr.delete();
    obsData.delete();
    applyStimulus(8'hA5, 0);
    checkOutput("rearm.done", 32'(done), 32'd0);
    checkOutput("rearm.hold", 32'(coreHold), 32'd1);
    checkOutput("rearm.busy", 32'(busy), 32'd1);
    pay[0] = 8'h0F; pay[1] = 8'hF0; pay[2] = 8'h77; pay[3] = 8'h01; pay[4] = 8'hFE; pay[5] = 8'h80;
    sendBody(3, 1'b0, 0, good);
    checkFrame(3, good, "rearm");

    $display("[TB] 256-word frame");
    for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
    runFrame(256, 1'b0, 0, 0, "len256");

    $display("[TB] clear after HI byte");
    obsAddr.delete();
    obsData.delete();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h12, 0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checkOutput("clr.ready", 32'(bus.rx_ready), 32'd1);
    checkOutput("clr.we", 32'(bus.pm_we), 32'd0);
    checkOutput("clr.addr", 32'(bus.pm_addr), 32'd0);
    checkOutput("clr.wdata", 32'(bus.pm_wdata), 32'd0);
    checkOutput("clr.hold", 32'(coreHold), 32'd1);
    checkOutput("clr.busy", 32'(busy), 32'd0);
    checkOutput("clr.done", 32'(done), 32'd0);
    checkOutput("clr.err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("clr.noWrite", 32'(obsAddr.size()), 32'd0);
    loadTwoWord();
    runFrame(2, 1'b0, 0, 0, "afterClr");

    $display("[TB] throttled 2-word frame");
    loadTwoWord();
    runFrame(2, 1'b0, 5, 0, "throttle");

    $display("[TB] random frames");
    for (int f = 0; f < 24; f++) begin
      words = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 256) : $urandom_range(1, 6);
      for (int i = 0; i < 2 * words; i++) pay[i] = 8'($urandom);
      runFrame(words, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
